// File: rtl/rv32i_types.sv
// rv32i_types: shared CDB payload layout, source ids and round-robin helper
package rv32i_types;
  localparam int CDB_TAG_W = 4;
  localparam int CDB_PTR_W = 4;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MDU = 2'd1, SRC_LSU = 2'd2} src_e;
  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_PTR_W-1:0] inst_id;
    logic [31:0]          wdata;
  } cdb_pkt_t;
  function automatic src_e src_add(src_e s, logic [1:0] k);
    logic [2:0] t;
    logic [2:0] u;
    t = {1'b0, s} + {1'b0, k};
    u = t >= 3'd3 ? t - 3'd3 : t;
    return src_e'(u[1:0]);
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result queue with ready derived from registered count
module cdb_src_fifo #(
  parameter int DW     = 40,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          valid,
  output logic          ready,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          nonempty,
  output logic [DW-1:0] head
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [QDEPTH];
  logic          push;
  always_comb begin
    ready    = cnt_q != CW'(QDEPTH);
    nonempty = cnt_q != '0;
    push     = valid && ready && !flush;
    head     = mem_q[rd_q];
    wr_d     = flush ? '0 : wr_q + AW'(push);
    rd_d     = flush ? '0 : rd_q + AW'(pop);
    cnt_d    = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/cdb_arb.sv
// cdb_arb: three queued result sources arbitrated round-robin onto one common data bus
module cdb_arb
  import rv32i_types::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int PTR_W  = CDB_PTR_W,
  parameter int QDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [PTR_W-1:0] alu_inst_id,
  input  logic [31:0]      alu_wdata,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [TAG_W-1:0] mdu_tag,
  input  logic [PTR_W-1:0] mdu_inst_id,
  input  logic [31:0]      mdu_wdata,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [TAG_W-1:0] lsu_tag,
  input  logic [PTR_W-1:0] lsu_inst_id,
  input  logic [31:0]      lsu_wdata,
  output logic             cdb_wr,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [PTR_W-1:0] cdb_inst_id,
  output logic [31:0]      cdb_wdata,
  output logic [1:0]       cdb_src
);
  localparam int DW = TAG_W + PTR_W + 32;
  logic [2:0]         valid, ready, nonempty, pop;
  logic [2:0][DW-1:0] din, head;
  logic [DW-1:0]      gnt_pkt;
  logic               any, gnt;
  src_e               rr_q, rr_d, gnt_idx;
  assign valid = {lsu_valid, mdu_valid, alu_valid};
  assign din   = {{lsu_tag, lsu_inst_id, lsu_wdata}, {mdu_tag, mdu_inst_id, mdu_wdata}, {alu_tag, alu_inst_id, alu_wdata}};
  assign {lsu_ready, mdu_ready, alu_ready} = ready;
  for (genvar i = 0; i < 3; i++) begin : g_q
    cdb_src_fifo #(.DW(DW), .QDEPTH(QDEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .valid    (valid[i]),
      .ready    (ready[i]),
      .din      (din[i]),
      .pop      (pop[i]),
      .nonempty (nonempty[i]),
      .head     (head[i])
    );
  end
  always_comb begin
    any     = 1'b0;
    gnt_idx = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (nonempty[src_add(rr_q, 2'(k))]) begin
        any     = 1'b1;
        gnt_idx = src_add(rr_q, 2'(k));
      end
    end
    gnt         = any && !flush;
    pop         = gnt ? 3'b001 << gnt_idx : 3'b000;
    gnt_pkt     = gnt ? head[gnt_idx] : '0;
    rr_d        = gnt ? src_add(gnt_idx, 2'd1) : rr_q;
    cdb_wr      = gnt;
    cdb_src     = gnt ? gnt_idx : 2'd0;
    {cdb_tag, cdb_inst_id, cdb_wdata} = gnt_pkt;
  end
  always_ff @(posedge clk) begin
    rr_q <= rst ? SRC_ALU : rr_d;
  end
endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: directed vector table plus hand sequences and a queue model for cdb_arb
module tb_cdb_arb;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        alu_valid = 1'b0, mdu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, mdu_ready, lsu_ready;
  logic [3:0]  alu_tag = '0, mdu_tag = '0, lsu_tag = '0;
  logic [3:0]  alu_inst_id = '0, mdu_inst_id = '0, lsu_inst_id = '0;
  logic [31:0] alu_wdata = '0, mdu_wdata = '0, lsu_wdata = '0;
  logic        cdb_wr;
  logic [3:0]  cdb_tag, cdb_inst_id;
  logic [31:0] cdb_wdata;
  logic [1:0]  cdb_src;
  int          n_vec = 0, n_bad = 0;
  logic [39:0] mq [3][$];
  int          rr_m = 0;
  int          shares [3];
  logic        done;
  typedef struct {
    logic        flush;
    logic [2:0]  v;
    logic [11:0] tags;
    logic        ew;
    logic [3:0]  etag;
    logic [1:0]  esrc;
    logic [2:0]  erdy;
  } vec_t;
  vec_t tbl [19];
  cdb_arb dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_tag     (alu_tag),
    .alu_inst_id (alu_inst_id),
    .alu_wdata   (alu_wdata),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_tag     (mdu_tag),
    .mdu_inst_id (mdu_inst_id),
    .mdu_wdata   (mdu_wdata),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_tag     (lsu_tag),
    .lsu_inst_id (lsu_inst_id),
    .lsu_wdata   (lsu_wdata),
    .cdb_wr      (cdb_wr),
    .cdb_tag     (cdb_tag),
    .cdb_inst_id (cdb_inst_id),
    .cdb_wdata   (cdb_wdata),
    .cdb_src     (cdb_src)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] dat_of(logic [3:0] t);
    return {16'hCAFE, 12'h000, t};
  endfunction
  function automatic vec_t mk(logic f, logic [2:0] v, logic [11:0] tg, logic ew, logic [3:0] et, logic [1:0] es, logic [2:0] er);
    vec_t r;
    r.flush = f;
    r.v     = v;
    r.tags  = tg;
    r.ew    = ew;
    r.etag  = et;
    r.esrc  = es;
    r.erdy  = er;
    return r;
  endfunction
  task automatic drive(input logic f, input logic [2:0] v, input logic [2:0][3:0] t, input logic [2:0][3:0] id, input logic [2:0][31:0] d);
    flush = f;
    {lsu_valid, mdu_valid, alu_valid} = v;
    alu_tag = t[0]; mdu_tag = t[1]; lsu_tag = t[2];
    alu_inst_id = id[0]; mdu_inst_id = id[1]; lsu_inst_id = id[2];
    alu_wdata = d[0]; mdu_wdata = d[1]; lsu_wdata = d[2];
  endtask
  task automatic drive_tags(input logic f, input logic [2:0] v, input logic [11:0] tags);
    logic [2:0][3:0]  t;
    logic [2:0][3:0]  id;
    logic [2:0][31:0] d;
    t = tags;
    for (int s = 0; s < 3; s++) begin
      id[s] = ~t[s];
      d[s]  = dat_of(t[s]);
    end
    drive(f, v, t, id, d);
  endtask
  task automatic check(input string name, input logic ew, input logic [3:0] et, input logic [3:0] ei, input logic [31:0] ed, input logic [1:0] es, input logic [2:0] er);
    logic [45:0] got;
    logic [45:0] want;
    got  = {cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src, lsu_ready, mdu_ready, alu_ready};
    want = {ew, et, ei, ed, es, er};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got wr=%b tag=%h id=%h data=%h src=%0d rdy=%b, want wr=%b tag=%h id=%h data=%h src=%0d rdy=%b",
               name, cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src, {lsu_ready, mdu_ready, alu_ready}, ew, et, ei, ed, es, er);
    end
  endtask
  function automatic logic [39:0] payload_of(int s);
    return s == 0 ? {alu_tag, alu_inst_id, alu_wdata} : s == 1 ? {mdu_tag, mdu_inst_id, mdu_wdata} : {lsu_tag, lsu_inst_id, lsu_wdata};
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    rr_m = 0;
  endtask
  task automatic model_step(input string name);
    logic [2:0]  er;
    logic [2:0]  v;
    logic        g_ok;
    int          g;
    logic [39:0] pay;
    v    = {lsu_valid, mdu_valid, alu_valid};
    g_ok = 1'b0;
    g    = 0;
    for (int s = 0; s < 3; s++) er[s] = mq[s].size() != 2;
    if (!flush) begin
      for (int k = 0; k < 3; k++) begin
        if (!g_ok && mq[(rr_m + k) % 3].size() != 0) begin
          g_ok = 1'b1;
          g    = (rr_m + k) % 3;
        end
      end
    end
    pay = g_ok ? mq[g][0] : 40'h0;
    check(name, g_ok, pay[39:36], pay[35:32], pay[31:0], g_ok ? 2'(g) : 2'd0, er);
    if (flush) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
    end else begin
      if (g_ok) begin
        void'(mq[g].pop_front());
        rr_m = (g + 1) % 3;
      end
      for (int s = 0; s < 3; s++) if (v[s] && er[s]) mq[s].push_back(payload_of(s));
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive_tags(1'b0, 3'b000, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0]  = mk(0, 3'b000, 12'h000, 0, 4'h0, 2'd0, 3'b111);
    tbl[1]  = mk(0, 3'b111, 12'h321, 0, 4'h0, 2'd0, 3'b111);
    tbl[2]  = mk(0, 3'b000, 12'h000, 1, 4'h1, 2'd0, 3'b111);
    tbl[3]  = mk(0, 3'b000, 12'h000, 1, 4'h2, 2'd1, 3'b111);
    tbl[4]  = mk(0, 3'b000, 12'h000, 1, 4'h3, 2'd2, 3'b111);
    tbl[5]  = mk(0, 3'b000, 12'h000, 0, 4'h0, 2'd0, 3'b111);
    tbl[6]  = mk(0, 3'b101, 12'h804, 0, 4'h0, 2'd0, 3'b111);
    tbl[7]  = mk(0, 3'b101, 12'h905, 1, 4'h4, 2'd0, 3'b111);
    tbl[8]  = mk(0, 3'b101, 12'hA06, 1, 4'h8, 2'd2, 3'b011);
    tbl[9]  = mk(0, 3'b101, 12'hA07, 1, 4'h5, 2'd0, 3'b110);
    tbl[10] = mk(0, 3'b000, 12'h000, 1, 4'h9, 2'd2, 3'b011);
    tbl[11] = mk(0, 3'b000, 12'h000, 1, 4'h6, 2'd0, 3'b111);
    tbl[12] = mk(0, 3'b000, 12'h000, 1, 4'hA, 2'd2, 3'b111);
    tbl[13] = mk(0, 3'b000, 12'h000, 0, 4'h0, 2'd0, 3'b111);
    tbl[14] = mk(0, 3'b111, 12'hEBD, 0, 4'h0, 2'd0, 3'b111);
    tbl[15] = mk(0, 3'b010, 12'h0C0, 1, 4'hD, 2'd0, 3'b111);
    tbl[16] = mk(1, 3'b001, 12'h00F, 0, 4'h0, 2'd0, 3'b101);
    tbl[17] = mk(0, 3'b000, 12'h000, 0, 4'h0, 2'd0, 3'b111);
    tbl[18] = mk(0, 3'b000, 12'h000, 0, 4'h0, 2'd0, 3'b111);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive_tags(tbl[i].flush, tbl[i].v, tbl[i].tags);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ew, tbl[i].ew ? tbl[i].etag : 4'h0, tbl[i].ew ? ~tbl[i].etag : 4'h0,
            tbl[i].ew ? dat_of(tbl[i].etag) : 32'h0, tbl[i].esrc, tbl[i].erdy);
      @(negedge clk);
    end
    do_reset();
    drive(1'b0, 3'b001, {4'h0, 4'h0, 4'h3}, {4'h0, 4'h0, 4'h5}, {32'h0, 32'h0, 32'hDEADBEEF});
    #1;
    check("single_push", 1'b0, 4'h0, 4'h0, 32'h0, 2'd0, 3'b111);
    @(negedge clk);
    drive_tags(1'b0, 3'b000, 12'h000);
    #1;
    check("single_bcast", 1'b1, 4'h3, 4'h5, 32'hDEADBEEF, 2'd0, 3'b111);
    @(negedge clk);
    #1;
    check("single_after", 1'b0, 4'h0, 4'h0, 32'h0, 2'd0, 3'b111);
    @(negedge clk);
    do_reset();
    shares = '{0, 0, 0};
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c < 30)
        drive(1'b0, 3'b111, {4'h3, 4'h2, 4'h1}, {4'(c), 4'(c), 4'(c)},
              {{8'd2, 8'(c), 16'h5A5A}, {8'd1, 8'(c), 16'h5A5A}, {8'd0, 8'(c), 16'h5A5A}});
      else
        drive_tags(1'b0, 3'b000, 12'h000);
      #1;
      if (cdb_wr && c >= 1 && c <= 30) shares[cdb_src]++;
      model_step($sformatf("stream%0d", c));
      @(negedge clk);
      if (c >= 30 && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL stream_drain: queues not empty after 60 cycles, want empty");
    end
    #1;
    model_step("stream_drained");
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (shares[s] != 10) begin
        n_bad++;
        $display("FAIL share_src%0d: got %0d grants, want 10", s, shares[s]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      drive_tags(1'b0, 3'b111, 12'h654);
      #1;
      model_step($sformatf("fill%0d", c));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_tags(1'b0, 3'b000, 12'h000);
    #1;
    check("post_rst", 1'b0, 4'h0, 4'h0, 32'h0, 2'd0, 3'b111);
    @(negedge clk);
    drive_tags(1'b0, 3'b111, 12'h789);
    #1;
    check("rst_push", 1'b0, 4'h0, 4'h0, 32'h0, 2'd0, 3'b111);
    @(negedge clk);
    drive_tags(1'b0, 3'b000, 12'h000);
    #1;
    check("rst_first_grant", 1'b1, 4'h9, 4'h6, dat_of(4'h9), 2'd0, 3'b111);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
